// File: rtl/tb_uart_monitor_mc.sv
// tb_uart_monitor_mc: multi-channel UART ICB snooper with pass/fail line matching, finish FSM and cycle benchmark
module tb_uart_monitor_mc #(
  parameter int NCH = 2,
  parameter int PASS_LEN = 16,
  parameter int FAIL_LEN = 16,
  parameter logic [255:0] PASS_STR = {128'h0, "NUCLEI_TEST_PASS"},
  parameter logic [255:0] FAIL_STR = {128'h0, "NUCLEI_TEST_FAIL"},
  parameter logic [7:0] EOT_CHAR = 8'h04,
  parameter int FINISH_DELAY = 20,
  parameter int CNT_W = 32
) (
  input  logic                tb_clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      uart_icb_cmd_valid,
  input  logic [NCH-1:0]      uart_icb_cmd_ready,
  input  logic [NCH-1:0]      uart_icb_cmd_read,
  input  logic [32*NCH-1:0]   uart_icb_cmd_addr,
  input  logic [8*NCH-1:0]    uart_icb_cmd_wdata,
  output logic [NCH-1:0]      tx_ena,
  output logic                test_pass,
  output logic                test_fail,
  output logic [2:0]          fail_chan,
  output logic                finish_req,
  output logic                finish,
  output logic                bench_valid,
  output logic [CNT_W-1:0]    bench_cycles
);
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} st_t;
  localparam logic [255:0] PMASK = (256'd1 << (8 * PASS_LEN)) - 256'd1;
  localparam logic [255:0] FMASK = (256'd1 << (8 * FAIL_LEN)) - 256'd1;
  localparam logic [10:0] FD1 = 11'(FINISH_DELAY - 1);
  st_t state, state_n;
  logic [10:0] dly, dly_n;
  logic [255:0] lbuf [NCH];
  logic [255:0] lbuf_n [NCH];
  logic [5:0] cnt [NCH];
  logic [5:0] cnt_n [NCH];
  logic [NCH-1:0] pass_hit, fail_hit, eot_hit, tx_ena_n;
  logic rx_v;
  logic [7:0] rx_d;
  logic [2:0] fail_idx;
  logic [CNT_W-1:0] cyc, start;
  logic armed;
  logic fire;
  logic [11:0] a;
  logic [7:0] d, u;
  logic [5:0] nc;
  // Per-channel decode, line-buffer update and string match; descending loop lets the lowest channel win
  always_comb begin
    pass_hit = '0;
    fail_hit = '0;
    eot_hit = '0;
    tx_ena_n = tx_ena;
    rx_v = 1'b0;
    rx_d = 8'h00;
    fail_idx = 3'd0;
    fire = 1'b0;
    a = 12'h0;
    d = 8'h0;
    u = 8'h0;
    nc = 6'd0;
    for (int c = NCH - 1; c >= 0; c--) begin
      fire = uart_icb_cmd_valid[c] & uart_icb_cmd_ready[c] & ~uart_icb_cmd_read[c];
      a = uart_icb_cmd_addr[32*c +: 12];
      d = uart_icb_cmd_wdata[8*c +: 8];
      u = (d >= 8'h61 && d <= 8'h7a) ? d - 8'h20 : d;
      nc = (cnt[c] == 6'd33) ? 6'd33 : cnt[c] + 6'd1;
      lbuf_n[c] = lbuf[c];
      cnt_n[c] = cnt[c];
      if (fire && a == 12'h000) begin
        if (d == 8'h0a || d == 8'h0d) begin
          cnt_n[c] = 6'd0;
        end else begin
          lbuf_n[c] = {lbuf[c][247:0], u};
          pass_hit[c] = (nc == 6'(PASS_LEN)) && (((lbuf_n[c] ^ PASS_STR) & PMASK) == '0);
          fail_hit[c] = (nc == 6'(FAIL_LEN)) && (((lbuf_n[c] ^ FAIL_STR) & FMASK) == '0);
          cnt_n[c] = pass_hit[c] ? 6'd0 : nc;
          eot_hit[c] = (d == EOT_CHAR);
        end
      end
      if (fire && a == 12'h004) begin
        rx_v = 1'b1;
        rx_d = d;
      end
      if (fire && a == 12'h008) tx_ena_n[c] = d[0];
      if (fail_hit[c]) fail_idx = 3'(c);
    end
  end
  // Finish FSM next state: fail jumps straight to DONE, pass/EOT start the drain delay once
  always_comb begin
    state_n = state;
    dly_n = dly;
    if (state != DONE && |fail_hit) begin
      state_n = DONE;
    end else if (state == IDLE && (|pass_hit || |eot_hit)) begin
      state_n = DRAIN;
      dly_n = 11'd0;
    end else if (state == DRAIN) begin
      dly_n = dly + 11'd1;
      state_n = (dly == FD1) ? DONE : DRAIN;
    end
  end
  // State, line buffers, sticky flags and benchmark registers
  always_ff @(posedge tb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dly <= '0;
      for (int c = 0; c < NCH; c++) begin
        lbuf[c] <= '0;
        cnt[c] <= '0;
      end
      tx_ena <= '0;
      test_pass <= 1'b0;
      test_fail <= 1'b0;
      fail_chan <= '0;
      finish_req <= 1'b0;
      finish <= 1'b0;
      cyc <= '0;
      start <= '0;
      armed <= 1'b0;
      bench_valid <= 1'b0;
      bench_cycles <= '0;
    end else begin
      state <= state_n;
      dly <= dly_n;
      for (int c = 0; c < NCH; c++) begin
        lbuf[c] <= lbuf_n[c];
        cnt[c] <= cnt_n[c];
      end
      tx_ena <= tx_ena_n;
      test_pass <= test_pass | (|pass_hit & ~|fail_hit);
      test_fail <= test_fail | |fail_hit;
      if (|fail_hit && !test_fail) fail_chan <= fail_idx;
      finish_req <= finish_req | (state_n != IDLE);
      finish <= (state_n == DONE);
      cyc <= cyc + 1'b1;
      bench_valid <= rx_v && rx_d == 8'h02 && armed;
      if (rx_v && rx_d == 8'h01) begin
        start <= cyc;
        armed <= 1'b1;
      end else if (rx_v && rx_d == 8'h02 && armed) begin
        bench_cycles <= cyc - start;
        armed <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tb_uart_monitor_mc.sv
// tb_tb_uart_monitor_mc: directed self-checking bench for tb_uart_monitor_mc
module tb_tb_uart_monitor_mc;
  localparam int NCH = 2;
  logic tb_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] valid = '0;
  logic [NCH-1:0] ready = '1;
  logic [NCH-1:0] read = '0;
  logic [32*NCH-1:0] addr = '0;
  logic [8*NCH-1:0] wdata = '0;
  logic [NCH-1:0] tx_ena;
  logic test_pass, test_fail, finish_req, finish, bench_valid;
  logic [2:0] fail_chan;
  logic [31:0] bench_cycles;
  int total = 0;
  int bad = 0;

  tb_uart_monitor_mc #(.NCH(NCH)) dut (
    .tb_clk(tb_clk), .rst_n(rst_n),
    .uart_icb_cmd_valid(valid), .uart_icb_cmd_ready(ready), .uart_icb_cmd_read(read),
    .uart_icb_cmd_addr(addr), .uart_icb_cmd_wdata(wdata),
    .tx_ena(tx_ena), .test_pass(test_pass), .test_fail(test_fail), .fail_chan(fail_chan),
    .finish_req(finish_req), .finish(finish), .bench_valid(bench_valid), .bench_cycles(bench_cycles)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one write cycle on the channels in v; returns 1ns after the firing edge
  task automatic wr_v(input logic [1:0] v, input logic [11:0] a0, input logic [7:0] d0,
                      input logic [11:0] a1, input logic [7:0] d1);
    valid = v;
    addr = {20'h0, a1, 20'h0, a0};
    wdata = {d1, d0};
    @(posedge tb_clk);
    #1;
    valid = '0;
  endtask

  task automatic wr(input int ch, input logic [11:0] a, input logic [7:0] d);
    if (ch == 0) wr_v(2'b01, a, d, 12'h0, 8'h0);
    else wr_v(2'b10, 12'h0, 8'h0, a, d);
  endtask

  task automatic tx_str(input int ch, input string s);
    for (int i = 0; i < s.len(); i++) wr(ch, 12'h000, s[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_pass", test_pass, 0);
    chk("rst_fail", test_fail, 0);
    chk("rst_finreq", finish_req, 0);
    chk("rst_finish", finish, 0);
    chk("rst_bvalid", bench_valid, 0);
    chk("rst_bcyc", bench_cycles, 0);
    chk("rst_txena", tx_ena, 0);
    do_reset();
    tx_str(0, "nuclei_test_pass");
    chk("lc_pass", test_pass, 1);
    chk("lc_finreq", finish_req, 1);
    chk("lc_fail", test_fail, 0);
    idle(19);
    chk("lc_finish_early", finish, 0);
    idle(1);
    chk("lc_finish", finish, 1);

    do_reset();
    tx_str(1, "xNUCLEI_TEST_PASS");
    wr(1, 12'h000, 8'h0a);
    chk("prefix_nopass", test_pass, 0);
    chk("prefix_nofinreq", finish_req, 0);
    tx_str(1, "NUCLEI_TEST_FAIL");
    chk("f1_fail", test_fail, 1);
    chk("f1_chan", fail_chan, 1);
    chk("f1_finish", finish, 1);
    chk("f1_finreq", finish_req, 1);
    chk("f1_pass", test_pass, 0);

    do_reset();
    wr(0, 12'h000, 8'h04);
    chk("eot_finreq", finish_req, 1);
    chk("eot_finish0", finish, 0);
    idle(9);
    wr(0, 12'h000, 8'h04);
    idle(9);
    chk("eot_norestart_early", finish, 0);
    idle(1);
    chk("eot_finish", finish, 1);

    wr(0, 12'h004, 8'h01);
    idle(999);
    wr(0, 12'h004, 8'h02);
    chk("bench_valid", bench_valid, 1);
    chk("bench_cycles", bench_cycles, 1000);
    idle(1);
    chk("bench_pulse_end", bench_valid, 0);
    wr(0, 12'h004, 8'h02);
    chk("bench_unarmed", bench_valid, 0);
    chk("bench_hold", bench_cycles, 1000);
    wr(1, 12'h004, 8'h01);
    idle(3);
    wr(0, 12'h004, 8'h01);
    wr(1, 12'h004, 8'h02);
    chk("bench_rearm", bench_cycles, 1);
    wr(0, 12'h004, 8'h01);
    wr_v(2'b11, 12'h004, 8'h02, 12'h004, 8'h01);
    chk("bench_low_wins_v", bench_valid, 1);
    chk("bench_low_wins_c", bench_cycles, 1);

    do_reset();
    tx_str(0, "NUCLEI_TEST_PAS");
    tx_str(1, "NUCLEI_TEST_FAI");
    chk("same_pre", finish_req, 0);
    wr_v(2'b11, 12'h000, "S", 12'h000, "L");
    chk("same_pass", test_pass, 0);
    chk("same_fail", test_fail, 1);
    chk("same_chan", fail_chan, 1);
    chk("same_finish", finish, 1);

    wr(1, 12'h008, 8'h01);
    chk("txena_set", tx_ena, 2'b10);
    wr(1, 12'h008, 8'h00);
    chk("txena_clr", tx_ena, 2'b00);

    do_reset();
    wr(1, 12'h008, 8'h01);
    wr(0, 12'h000, 8'h04);
    idle(5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_finreq", finish_req, 0);
    chk("mid_rst_txena", tx_ena, 0);
    chk("mid_rst_finish", finish, 0);
    #1;
    rst_n = 1'b1;
    @(posedge tb_clk);
    #1;
    wr(0, 12'h000, 8'h04);
    chk("post_rst_finreq", finish_req, 1);
    idle(19);
    chk("post_rst_early", finish, 0);
    idle(1);
    chk("post_rst_finish", finish, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
